// File: rtl/signal_change_logger_pkg.sv
// -----------------------------------------------------------------------------
// signal_change_logger_pkg
// Shared types, constants and helpers for the signal change logger and the
// trace formatter that consumes its records.
//
// Record layout (rec_data): { timestamp[TS_WIDTH-1:0], value[WIDTH-1:0] }
//   value     occupies bits [val_msb(WIDTH):VAL_LSB]
//   timestamp occupies bits [ts_msb(WIDTH,TS_WIDTH):ts_lsb(WIDTH)]
// -----------------------------------------------------------------------------
package signal_change_logger_pkg;

    // Width of the saturating dropped-record counter.
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    // Default configuration, shared with the trace formatter.
    localparam int DEF_WIDTH    = 3;
    localparam int DEF_TS_WIDTH = 32;

    // Field offsets inside a record. The value always sits at bit 0.
    localparam int VAL_LSB = 0;
    localparam int DEF_TS_LSB = DEF_WIDTH;
    localparam int DEF_TS_MSB = DEF_WIDTH + DEF_TS_WIDTH - 1;

    // Total record width for a given configuration.
    function automatic int rec_width(input int width, input int ts_width);
        return width + ts_width;
    endfunction

    // Timestamp field sits directly above the value field.
    function automatic int ts_lsb(input int width);
        return width;
    endfunction

    function automatic int ts_msb(input int width, input int ts_width);
        return width + ts_width - 1;
    endfunction

    function automatic int val_msb(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/signal_change_logger_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head output. Occupancy is tracked in an
// explicit level counter; full/empty derive from it so the pointers can wrap
// freely. A push while full is accepted only if a pop happens in the same
// cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   push   in   write request (ignored when full without a pop)
//   pop    in   read request  (ignored when empty)
//   din    in   write data
//   dout   out  current head entry, zero when empty
//   level  out  occupancy, 0..DEPTH
//   full   out  level == DEPTH
//   empty  out  level == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [DATA_W-1:0] head_q,   head_d;

    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] rd_next;

    assign empty = (level_q == {LVL_W{1'b0}});
    assign full  = (level_q == DEPTH_LVL);
    assign dout  = head_q;
    assign level = level_q;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    // Next-state for pointers, level and the registered head entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok) begin
            rd_ptr_d = rd_next;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // The head register must hold whatever entry will sit at rd_ptr_d.
        // When that entry is being written this very cycle it is not yet in
        // mem_q, so it is taken straight from din.
        if (level_d == {LVL_W{1'b0}}) begin
            head_d = {DATA_W{1'b0}};
        end else if (pop_ok) begin
            if (push_ok && (wr_ptr_q == rd_next)) begin
                head_d = din;
            end else begin
                head_d = mem_q[rd_next];
            end
        end else if (empty) begin
            head_d = din;
        end else begin
            head_d = head_q;
        end
    end

    // Pointer, level and head registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            head_q   <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are only meaningful between rd and wr pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/signal_change_logger.sv
// -----------------------------------------------------------------------------
// signal_change_logger
// Hardware counterpart of a $monitor trace. Samples sample_in every clock,
// and whenever it changes (or on the first enabled cycle after reset or
// re-enable) pushes {timestamp, value} into a FIFO drained over valid/ready.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   enable      in   monitoring on; records only generated while high
//   sample_in   in   monitored vector
//   rec_valid   out  FIFO head record available
//   rec_ready   in   consumer accepts head this cycle
//   rec_data    out  {timestamp, value}, timestamp in MSBs; zero when empty
//   level       out  FIFO occupancy
//   overflow    out  sticky, at least one record dropped
//   drop_count  out  dropped records, saturating at 255
// -----------------------------------------------------------------------------
module signal_change_logger
    import signal_change_logger_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int TS_WIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [WIDTH-1:0]                     sample_in,
    output logic                                 rec_valid,
    input  logic                                 rec_ready,
    output logic [rec_width(WIDTH, TS_WIDTH)-1:0] rec_data,
    output logic [$clog2(DEPTH):0]               level,
    output logic                                 overflow,
    output logic [DROP_CNT_W-1:0]                drop_count
);

    localparam int REC_W = rec_width(WIDTH, TS_WIDTH);

    logic [TS_WIDTH-1:0]   ts_q,       ts_d;
    logic [WIDTH-1:0]      prev_q,     prev_d;
    logic                  init_q,     init_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_q,     drop_d;

    logic             push_req;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic [REC_W-1:0] rec_word;

    // A record is due on a change, or unconditionally on the first enabled
    // cycle after reset / re-enable so the consumer always sees a baseline.
    assign push_req = enable && (init_q || (sample_in != prev_q));
    assign fifo_pop = rec_ready && !fifo_empty;
    assign drop     = push_req && fifo_full && !fifo_pop;
    assign rec_word = {ts_q, sample_in};

    // Next-state for timestamp, change detector and drop accounting.
    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1);
        prev_d     = sample_in;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        // Low enable re-arms the baseline record; any enabled cycle consumes it.
        if (enable) begin
            init_d = 1'b0;
        end else begin
            init_d = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != DROP_CNT_MAX) begin
                drop_d = drop_q + 8'd1;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_d     = drop_q;
        end
    end

    // Timestamp, change detector and drop accounting registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q       <= {TS_WIDTH{1'b0}};
            prev_q     <= {WIDTH{1'b0}};
            init_q     <= 1'b1;
            overflow_q <= 1'b0;
            drop_q     <= {DROP_CNT_W{1'b0}};
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            init_q     <= init_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (rec_word),
        .dout  (rec_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rec_valid  = !fifo_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_signal_change_logger.sv
// -----------------------------------------------------------------------------
// tb_signal_change_logger
// Directed bench for signal_change_logger (WIDTH=3, TS_WIDTH=32, DEPTH=4).
// Inputs change on the falling edge; outputs are observed on the falling edge,
// so each observation reflects every rising edge so far. After do_reset the
// next rising edge is the ts=0 cycle.
// -----------------------------------------------------------------------------
module tb_signal_change_logger;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  sample_in;
    logic        rec_valid;
    logic        rec_ready;
    logic [34:0] rec_data;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    signal_change_logger #(
        .WIDTH    (3),
        .TS_WIDTH (32),
        .DEPTH    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sample_in  (sample_in),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rec(input logic [31:0] ts, input logic [2:0] v);
        return {29'd0, ts, v};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        rec_ready = 1'b0;
        sample_in = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [63:0] exp_q [$];

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        rec_ready = 1'b0;
        sample_in = 3'b000;

        // ---------------- Initial record ----------------
        do_reset();
        check_eq("rst_valid",    64'(rec_valid),  64'd0);
        check_eq("rst_level",    64'(level),      64'd0);
        check_eq("rst_data",     64'(rec_data),   64'd0);
        check_eq("rst_overflow", 64'(overflow),   64'd0);
        check_eq("rst_drop",     64'(drop_count), 64'd0);
        enable = 1'b1; sample_in = 3'b001; rec_ready = 1'b1;
        tick();
        check_eq("init_valid", 64'(rec_valid), 64'd1);
        check_eq("init_data",  64'(rec_data),  rec(32'd0, 3'b001));
        check_eq("init_level", 64'(level),     64'd1);
        tick();
        check_eq("init_popped_valid", 64'(rec_valid), 64'd0);
        check_eq("init_popped_data",  64'(rec_data),  64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("static_no_rec", 64'(rec_valid), 64'd0);
        end

        // ---------------- Swap pattern ----------------
        do_reset();
        enable = 1'b1; sample_in = 3'b001; rec_ready = 1'b1;
        tick();
        check_eq("swap_r0", 64'(rec_data), rec(32'd0, 3'b001));
        sample_in = 3'b101;
        tick();
        check_eq("swap_r1",    64'(rec_data), rec(32'd1, 3'b101));
        check_eq("swap_lvl1",  64'(level),    64'd1);
        sample_in = 3'b110;
        tick();
        check_eq("swap_r2",    64'(rec_data), rec(32'd2, 3'b110));
        check_eq("swap_lvl2",  64'(level),    64'd1);
        tick();
        check_eq("swap_done",  64'(rec_valid), 64'd0);

        // ---------------- Overflow ----------------
        do_reset();
        enable = 1'b1; sample_in = 3'b001; rec_ready = 1'b0;
        tick();
        check_eq("ovf_lvl_init", 64'(level), 64'd1);
        for (int i = 0; i < 6; i++) begin
            sample_in = (i % 2 == 0) ? 3'b110 : 3'b001;
            tick();
        end
        check_eq("ovf_level", 64'(level),      64'd4);
        check_eq("ovf_flag",  64'(overflow),   64'd1);
        check_eq("ovf_drops", 64'(drop_count), 64'd3);
        check_eq("ovf_head",  64'(rec_data),   rec(32'd0, 3'b001));
        exp_q = '{rec(32'd1, 3'b110), rec(32'd2, 3'b001), rec(32'd3, 3'b110)};
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("ovf_drain_data",  64'(rec_data), exp_q[i]);
            check_eq("ovf_drain_level", 64'(level),    64'(3 - i));
        end
        tick();
        check_eq("ovf_drained",     64'(rec_valid),  64'd0);
        check_eq("ovf_sticky",      64'(overflow),   64'd1);
        check_eq("ovf_drops_kept",  64'(drop_count), 64'd3);

        // ---------------- Full with pop ----------------
        do_reset();
        enable = 1'b1; sample_in = 3'b001; rec_ready = 1'b0;
        tick();
        sample_in = 3'b110; tick();
        sample_in = 3'b001; tick();
        sample_in = 3'b110; tick();
        check_eq("fp_full_level", 64'(level),      64'd4);
        check_eq("fp_full_drop",  64'(drop_count), 64'd0);
        sample_in = 3'b001; rec_ready = 1'b1;
        tick();
        check_eq("fp_level",    64'(level),      64'd4);
        check_eq("fp_drop",     64'(drop_count), 64'd0);
        check_eq("fp_overflow", 64'(overflow),   64'd0);
        check_eq("fp_head",     64'(rec_data),   rec(32'd1, 3'b110));
        sample_in = 3'b110; rec_ready = 1'b0;
        tick();
        check_eq("fp_drop_after", 64'(drop_count), 64'd1);
        check_eq("fp_ovf_after",  64'(overflow),   64'd1);
        check_eq("fp_head_hold",  64'(rec_data),   rec(32'd1, 3'b110));
        exp_q = '{rec(32'd2, 3'b001), rec(32'd3, 3'b110), rec(32'd4, 3'b001)};
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("fp_drain_data", 64'(rec_data), exp_q[i]);
        end

        // ---------------- Re-enable ----------------
        do_reset();
        enable = 1'b1; sample_in = 3'b001; rec_ready = 1'b1;
        tick();
        check_eq("re_first", 64'(rec_data), rec(32'd0, 3'b001));
        enable = 1'b0;
        sample_in = 3'b100; tick();
        check_eq("re_dis0", 64'(rec_valid), 64'd0);
        sample_in = 3'b111; tick();
        check_eq("re_dis1", 64'(rec_valid), 64'd0);
        sample_in = 3'b011; tick();
        check_eq("re_dis2", 64'(rec_valid), 64'd0);
        enable = 1'b1; sample_in = 3'b010;
        tick();
        check_eq("re_rec",   64'(rec_data), rec(32'd4, 3'b010));
        check_eq("re_level", 64'(level),    64'd1);
        enable = 1'b0;
        tick();
        check_eq("re_only_one", 64'(rec_valid), 64'd0);
        enable = 1'b1;
        tick();
        check_eq("re_same_value", 64'(rec_data), rec(32'd6, 3'b010));

        // ---------------- Reset mid-stream ----------------
        do_reset();
        enable = 1'b1; sample_in = 3'b001; rec_ready = 1'b0;
        tick();
        sample_in = 3'b110; tick();
        sample_in = 3'b001; tick();
        check_eq("mid_pending", 64'(level), 64'd3);
        sample_in = 3'b110; tick();
        sample_in = 3'b001; tick();
        check_eq("mid_ovf_pre", 64'(overflow), 64'd1);
        reset = 1'b1; sample_in = 3'b111;
        tick();
        check_eq("mid_valid", 64'(rec_valid),  64'd0);
        check_eq("mid_level", 64'(level),      64'd0);
        check_eq("mid_ovf",   64'(overflow),   64'd0);
        check_eq("mid_drop",  64'(drop_count), 64'd0);
        check_eq("mid_data",  64'(rec_data),   64'd0);
        reset = 1'b0; sample_in = 3'b001; rec_ready = 1'b1;
        tick();
        check_eq("mid_ts_restart", 64'(rec_data), rec(32'd0, 3'b001));

        // ---------------- Drop counter saturation ----------------
        do_reset();
        enable = 1'b1; rec_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sample_in = (i % 2 == 0) ? 3'b001 : 3'b110;
            tick();
        end
        check_eq("sat_drop",  64'(drop_count), 64'd255);
        check_eq("sat_level", 64'(level),      64'd4);
        check_eq("sat_head",  64'(rec_data),   rec(32'd0, 3'b001));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
